// File: rtl/sync_ram_arb2.sv
// rtl/sync_ram_arb2.sv - two-port arbiter/sequencer in front of one synchronous-read RAM
// Macro SYNC_RAM_ARB2_RR_EN selects round-robin arbitration; undefined gives fixed priority to port 0.

module SYNC_RAM #(
    parameter int    DWIDTH  = 32,
    parameter int    AWIDTH  = 8,
    parameter string MIF_HEX = ""
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] d,
    output logic [DWIDTH-1:0] q
);

    logic [DWIDTH-1:0] mem [2**AWIDTH];
    logic [DWIDTH-1:0] q_q;

    // Write and read share one port; q holds its last value across writes and idle cycles.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= d;
            end else begin
                q_q <= mem[addr];
            end
        end
    end

    assign q = q_q;

endmodule

module sync_ram_arb2 #(
    parameter int    DWIDTH  = 32,
    parameter int    AWIDTH  = 8,
    parameter string MIF_HEX = ""
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic [AWIDTH-1:0] p0_addr,
    input  logic [DWIDTH-1:0] p0_wdata,
    output logic              p0_rvalid,
    output logic [DWIDTH-1:0] p0_rdata,

    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic [AWIDTH-1:0] p1_addr,
    input  logic [DWIDTH-1:0] p1_wdata,
    output logic              p1_rvalid,
    output logic [DWIDTH-1:0] p1_rdata
);

    logic              gnt0;
    logic              gnt1;
    logic              any_gnt;
    logic              ram_we;
    logic [AWIDTH-1:0] ram_addr;
    logic [DWIDTH-1:0] ram_d;
    logic [DWIDTH-1:0] ram_q;

    logic              rd_pend_d, rd_pend_q;
    logic              rd_port_d, rd_port_q;

`ifdef SYNC_RAM_ARB2_RR_EN
    logic              prio_d, prio_q;
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (p0_valid && p1_valid) begin
`ifdef SYNC_RAM_ARB2_RR_EN
                gnt0 = ~prio_q;
                gnt1 = prio_q;
`else
                gnt0 = 1'b1;
`endif
            end else begin
                gnt0 = p0_valid;
                gnt1 = p1_valid;
            end
        end
    end

    always_comb begin
        any_gnt  = gnt0 | gnt1;
        ram_we   = gnt1 ? p1_we    : p0_we;
        ram_addr = gnt1 ? p1_addr  : p0_addr;
        ram_d    = gnt1 ? p1_wdata : p0_wdata;
    end

    always_comb begin
        rd_pend_d = any_gnt && !ram_we;
        rd_port_d = rd_port_q;
        if (any_gnt && !ram_we) begin
            rd_port_d = gnt1;
        end
    end

`ifdef SYNC_RAM_ARB2_RR_EN
    // The loser of each grant gets first claim on the next contended cycle.
    always_comb begin
        prio_d = prio_q;
        if (any_gnt) begin
            prio_d = ~gnt1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q <= 1'b0;
            rd_port_q <= 1'b0;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_port_q <= rd_port_d;
        end
    end

    SYNC_RAM #(
        .DWIDTH  (DWIDTH),
        .AWIDTH  (AWIDTH),
        .MIF_HEX (MIF_HEX)
    ) u_ram (
        .clk  (clk),
        .en   (any_gnt),
        .we   (ram_we),
        .addr (ram_addr),
        .d    (ram_d),
        .q    (ram_q)
    );

    // Gating with rst drops a response whose cycle coincides with reset.
    assign p0_ready  = gnt0;
    assign p1_ready  = gnt1;
    assign p0_rvalid = rd_pend_q && (rd_port_q == 1'b0) && !rst;
    assign p1_rvalid = rd_pend_q && (rd_port_q == 1'b1) && !rst;
    assign p0_rdata  = ram_q;
    assign p1_rdata  = ram_q;

endmodule

// File: tb/tb_sync_ram_arb2.sv
// tb/tb_sync_ram_arb2.sv - randomized bench for sync_ram_arb2 against a transaction-level model

module tb_sync_ram_arb2;

    localparam int DW = 32;
    localparam int AW = 8;
`ifdef SYNC_RAM_ARB2_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_valid, p0_we, p0_ready, p0_rvalid;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_valid, p1_we, p1_ready, p1_rvalid;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mdl_mem [2**AW];
    bit            mdl_last_loser;
    bit            mdl_pend;
    bit            mdl_pend_port;
    logic [DW-1:0] mdl_pend_data;

    always #5 clk = ~clk;

    sync_ram_arb2 #(.DWIDTH(DW), .AWIDTH(AW), .MIF_HEX("")) dut (
        .clk       (clk),
        .rst       (rst),
        .p0_valid  (p0_valid),
        .p0_ready  (p0_ready),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_valid  (p1_valid),
        .p1_ready  (p1_ready),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, check at the falling edge, then advance the model and the clock.
    task automatic cycle(input bit r,
                         input bit v0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit v1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        int            g;
        bit            gwe;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        rst = r;
        p0_valid = v0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_valid = v1; p1_we = w1; p1_addr = a1; p1_wdata = d1;

        if (r)             g = -1;
        else if (v0 && v1) g = (RR && mdl_last_loser) ? 1 : 0;
        else if (v0)       g = 0;
        else if (v1)       g = 1;
        else               g = -1;

        #4;
        check("p0_ready", {63'd0, p0_ready}, {63'd0, g == 0});
        check("p1_ready", {63'd0, p1_ready}, {63'd0, g == 1});
        check("p0_rvalid", {63'd0, p0_rvalid}, {63'd0, mdl_pend && !r && !mdl_pend_port});
        check("p1_rvalid", {63'd0, p1_rvalid}, {63'd0, mdl_pend && !r && mdl_pend_port});
        if (mdl_pend && !r && !mdl_pend_port) check("p0_rdata", {32'd0, p0_rdata}, {32'd0, mdl_pend_data});
        if (mdl_pend && !r &&  mdl_pend_port) check("p1_rdata", {32'd0, p1_rdata}, {32'd0, mdl_pend_data});

        mdl_pend = 1'b0;
        if (r) begin
            mdl_last_loser = 1'b0;
        end else if (g >= 0) begin
            gwe = (g == 1) ? w1 : w0;
            ga  = (g == 1) ? a1 : a0;
            gd  = (g == 1) ? d1 : d0;
            mdl_last_loser = (g == 0);
            if (gwe) begin
                mdl_mem[ga] = gd;
            end else begin
                mdl_pend      = 1'b1;
                mdl_pend_port = (g == 1);
                mdl_pend_data = mdl_mem[ga];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    initial begin
        mdl_last_loser = 1'b0;
        mdl_pend       = 1'b0;
        mdl_pend_port  = 1'b0;
        mdl_pend_data  = '0;
        rst = 1'b1;
        p0_valid = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_valid = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        @(posedge clk);
        #1;

        // Reset holds off requests on both ports.
        cycle(1, 1, 0, 8'h01, '0, 1, 0, 8'h02, '0);
        cycle(1, 1, 1, 8'h03, 32'h1, 1, 1, 8'h04, 32'h2);

        // Preload every word, alternating ports, single requester per cycle.
        for (int i = 0; i < 2**AW; i++) begin
            if (i % 2 == 0) cycle(0, 1, 1, AW'(i), $urandom, 0, 0, '0, '0);
            else            cycle(0, 0, 0, '0, '0, 1, 1, AW'(i), $urandom);
        end
        idle();

        // Port 0 writes, port 1 reads the same address next cycle.
        cycle(0, 1, 1, 8'h10, 32'hDEADBEEF, 0, 0, '0, '0);
        cycle(0, 0, 0, '0, '0, 1, 0, 8'h10, '0);
        idle();
        idle();

        // Contended reads for 4 cycles after a fresh reset.
        cycle(1, 0, 0, '0, '0, 0, 0, '0, '0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, AW'(i), '0, 1, 0, AW'(8 + i), '0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, '0, 1, 0, AW'(8 + i), '0);
        idle();

        // Read granted, then reset the next cycle: response must vanish; then contention after reset.
        cycle(0, 1, 0, 8'h20, '0, 0, 0, '0, '0);
        cycle(1, 0, 0, '0, '0, 0, 0, '0, '0);
        cycle(0, 1, 0, 8'h21, '0, 1, 0, 8'h22, '0);
        idle();

        // Write then read of the same address from port 0.
        cycle(0, 1, 1, 8'h33, 32'hCAFEF00D, 0, 0, '0, '0);
        cycle(0, 1, 0, 8'h33, '0, 0, 0, '0, '0);
        idle();

        // Lone port 1 request gets no bubble; then contention shows who has priority.
        cycle(0, 0, 0, '0, '0, 1, 0, 8'h44, '0);
        cycle(0, 1, 0, 8'h45, '0, 1, 0, 8'h46, '0);
        cycle(0, 1, 0, 8'h45, '0, 1, 0, 8'h46, '0);
        idle();

        // Top address on both ports.
        cycle(0, 1, 1, 8'hFF, 32'h5A5A1234, 0, 0, '0, '0);
        cycle(0, 0, 0, '0, '0, 1, 0, 8'hFF, '0);
        cycle(0, 0, 0, '0, '0, 1, 1, 8'hFF, 32'h0BADC0DE);
        cycle(0, 1, 0, 8'hFF, '0, 0, 0, '0, '0);
        idle();

        // Random traffic with occasional reset and address reuse.
        for (int i = 0; i < 600; i++) begin
            bit            r, v0, v1, w0, w1;
            logic [AW-1:0] a0, a1;
            r  = ($urandom_range(0, 39) == 0);
            v0 = $urandom_range(0, 3) != 0;
            v1 = $urandom_range(0, 3) != 0;
            w0 = $urandom_range(0, 2) == 0;
            w1 = $urandom_range(0, 2) == 0;
            a0 = ($urandom_range(0, 3) == 0) ? 8'hFF : AW'($urandom_range(0, 15));
            a1 = ($urandom_range(0, 3) == 0) ? a0    : AW'($urandom_range(0, 15));
            cycle(r, v0, w0, a0, $urandom, v1, w1, a1, $urandom);
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
